// File: rtl/control_pipe_if.sv
// Control bundle interface between the decode logic and the pipeline
// control block: decoded ID-stage fields in, per-stage controls, stall
// and forwarding selects out.
interface control_pipe_if #(
  parameter int REG_AW = 5,
  parameter int AOP_W  = 2
);
  logic              id_branch_i;
  logic              id_memread_i;
  logic              id_memwrite_i;
  logic              id_memtoreg_i;
  logic              id_alusrc_i;
  logic [AOP_W-1:0]  id_aluop_i;
  logic              id_regwrite_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              flush_i;

  logic              stall_o;
  logic              ex_alusrc_o;
  logic [AOP_W-1:0]  ex_aluop_o;
  logic              ex_branch_o;
  logic [1:0]        forward_a_o;
  logic [1:0]        forward_b_o;
  logic              mem_memread_o;
  logic              mem_memwrite_o;
  logic [REG_AW-1:0] mem_rd_o;
  logic              wb_memtoreg_o;
  logic              wb_regwrite_o;
  logic [REG_AW-1:0] wb_rd_o;

  // Decode side: drives the ID bundle and flush, observes the controls.
  modport master (
    output id_branch_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
           id_alusrc_i, id_aluop_i, id_regwrite_i,
           id_rs1_i, id_rs2_i, id_rd_i, flush_i,
    input  stall_o, ex_alusrc_o, ex_aluop_o, ex_branch_o,
           forward_a_o, forward_b_o, mem_memread_o, mem_memwrite_o,
           mem_rd_o, wb_memtoreg_o, wb_regwrite_o, wb_rd_o
  );

  // Pipeline control block side.
  modport slave (
    input  id_branch_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
           id_alusrc_i, id_aluop_i, id_regwrite_i,
           id_rs1_i, id_rs2_i, id_rd_i, flush_i,
    output stall_o, ex_alusrc_o, ex_aluop_o, ex_branch_o,
           forward_a_o, forward_b_o, mem_memread_o, mem_memwrite_o,
           mem_rd_o, wb_memtoreg_o, wb_regwrite_o, wb_rd_o
  );
endinterface

// File: rtl/control_pipe.sv
// Pipeline control carrier: moves the decoded control bundle through the
// ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards (one-cycle
// stall with bubble) and produces the EX-stage operand forwarding selects.
module control_pipe #(
  parameter int REG_AW = 5,
  parameter int AOP_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  control_pipe_if.slave       bus
);

  typedef struct packed {
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [AOP_W-1:0]  aluop;
    logic              regwrite;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
    logic [REG_AW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic [REG_AW-1:0] rd;
  } mem_wb_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  id_ex_t  ex_q;
  ex_mem_t mem_q;
  mem_wb_t wb_q;

  id_ex_t  id_bundle;
  logic    stall;
  logic    bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign id_bundle = '{
    branch:   bus.id_branch_i,
    memread:  bus.id_memread_i,
    memwrite: bus.id_memwrite_i,
    memtoreg: bus.id_memtoreg_i,
    alusrc:   bus.id_alusrc_i,
    aluop:    bus.id_aluop_i,
    regwrite: bus.id_regwrite_i,
    rs1:      bus.id_rs1_i,
    rs2:      bus.id_rs2_i,
    rd:       bus.id_rd_i
  };

  // Load-use: a load in EX whose (non-x0) destination is read by ID.
  // Opcode is ignored, so unused rs fields can cause a harmless extra stall.
  assign stall = ex_q.memread && (ex_q.rd != '0) &&
                 ((ex_q.rd == bus.id_rs1_i) || (ex_q.rd == bus.id_rs2_i));

  // Stall and flush both just turn the ID/EX load into a bubble.
  assign bubble = stall || bus.flush_i;

  // Stage registers; all three stages advance on every edge.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= bubble ? '0 : id_bundle;
      mem_q <= '{memread:  ex_q.memread,
                 memwrite: ex_q.memwrite,
                 memtoreg: ex_q.memtoreg,
                 regwrite: ex_q.regwrite,
                 rd:       ex_q.rd};
      wb_q  <= '{memtoreg: mem_q.memtoreg,
                 regwrite: mem_q.regwrite,
                 rd:       mem_q.rd};
    end
  end

  // Forwarding selects: EX/MEM wins over MEM/WB, x0 never forwards.
  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1))
      fwd_a = FWD_MEM;
    else if (wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs1))
      fwd_a = FWD_WB;
    if (mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2))
      fwd_b = FWD_MEM;
    else if (wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs2))
      fwd_b = FWD_WB;
  end

  assign bus.stall_o        = stall;
  assign bus.ex_alusrc_o    = ex_q.alusrc;
  assign bus.ex_aluop_o     = ex_q.aluop;
  assign bus.ex_branch_o    = ex_q.branch;
  assign bus.forward_a_o    = fwd_a;
  assign bus.forward_b_o    = fwd_b;
  assign bus.mem_memread_o  = mem_q.memread;
  assign bus.mem_memwrite_o = mem_q.memwrite;
  assign bus.mem_rd_o       = mem_q.rd;
  assign bus.wb_memtoreg_o  = wb_q.memtoreg;
  assign bus.wb_regwrite_o  = wb_q.regwrite;
  assign bus.wb_rd_o        = wb_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: reset, load-use stall, x0 guard,
// forwarding priority, flush and asynchronous reset mid-pipe.
module tb_control_pipe;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  control_pipe_if #(.REG_AW(5), .AOP_W(2)) bus ();

  control_pipe #(.REG_AW(5), .AOP_W(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  wire [22:0] all_outs = {bus.stall_o, bus.ex_alusrc_o, bus.ex_aluop_o,
                          bus.ex_branch_o, bus.forward_a_o, bus.forward_b_o,
                          bus.mem_memread_o, bus.mem_memwrite_o, bus.mem_rd_o,
                          bus.wb_memtoreg_o, bus.wb_regwrite_o, bus.wb_rd_o};
  wire [3:0]  ex_ctl   = {bus.ex_alusrc_o, bus.ex_aluop_o, bus.ex_branch_o};

  task automatic set_id(input logic br, input logic mr, input logic mw,
                        input logic mt, input logic as, input logic [1:0] aop,
                        input logic rw, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    bus.id_branch_i   = br;
    bus.id_memread_i  = mr;
    bus.id_memwrite_i = mw;
    bus.id_memtoreg_i = mt;
    bus.id_alusrc_i   = as;
    bus.id_aluop_i    = aop;
    bus.id_regwrite_i = rw;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_rd_i       = rd;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    nop();
    bus.flush_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    bus.flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_id($urandom, $urandom, $urandom, $urandom, $urandom, 2'($urandom),
             $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      tick();
      n_checks++;
      if (all_outs !== 23'd0) begin
        n_errors++;
        $display("FAIL reset_outs[%0d]: got %h expected 0", i, all_outs);
      end
    end
    #3 rst_i = 1'b1;
    // R-type: regwrite, aluop=10, rd=5
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd1, 5'd2, 5'd5);
    tick();
    n_checks++;
    if (bus.ex_aluop_o !== 2'b10) begin
      n_errors++;
      $display("FAIL rtype_ex_aluop: got %b expected 10", bus.ex_aluop_o);
    end
    nop();
    tick();
    n_checks++;
    if (bus.mem_rd_o !== 5'd5) begin
      n_errors++;
      $display("FAIL rtype_mem_rd: got %0d expected 5", bus.mem_rd_o);
    end
    tick();
    n_checks++;
    if ({bus.wb_regwrite_o, bus.wb_rd_o} !== {1'b1, 5'd5}) begin
      n_errors++;
      $display("FAIL rtype_wb: got rw=%b rd=%0d expected rw=1 rd=5",
               bus.wb_regwrite_o, bus.wb_rd_o);
    end
    drain();
  endtask

  task automatic test_load_use();
    // load x3 <- mem[x1]
    set_id(0, 1, 0, 1, 1, 2'b00, 1, 5'd1, 5'd0, 5'd3);
    tick();
    // dependent: add x6 = x3 + x4
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd3, 5'd4, 5'd6);
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b1) begin
      n_errors++;
      $display("FAIL loaduse_stall: got %b expected 1", bus.stall_o);
    end
    tick();
    n_checks++;
    if (ex_ctl !== 4'd0) begin
      n_errors++;
      $display("FAIL loaduse_bubble: got %b expected 0000", ex_ctl);
    end
    n_checks++;
    if (bus.stall_o !== 1'b0) begin
      n_errors++;
      $display("FAIL loaduse_stall_clear: got %b expected 0", bus.stall_o);
    end
    n_checks++;
    if ({bus.mem_memread_o, bus.mem_rd_o} !== {1'b1, 5'd3}) begin
      n_errors++;
      $display("FAIL loaduse_mem: got mr=%b rd=%0d expected mr=1 rd=3",
               bus.mem_memread_o, bus.mem_rd_o);
    end
    tick();
    n_checks++;
    if (bus.ex_aluop_o !== 2'b10) begin
      n_errors++;
      $display("FAIL loaduse_dep_ex: got %b expected 10", bus.ex_aluop_o);
    end
    n_checks++;
    if ({bus.forward_a_o, bus.forward_b_o} !== 4'b01_00) begin
      n_errors++;
      $display("FAIL loaduse_fwd: got a=%b b=%b expected a=01 b=00",
               bus.forward_a_o, bus.forward_b_o);
    end
    drain();
  endtask

  task automatic test_x0_guard();
    // load into x0, then reader of x0
    set_id(0, 1, 0, 1, 1, 2'b00, 1, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd0, 5'd0, 5'd9);
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0) begin
      n_errors++;
      $display("FAIL x0_stall: got %b expected 0", bus.stall_o);
    end
    tick();
    nop();
    #1;
    n_checks++;
    if (bus.forward_a_o !== 2'b00) begin
      n_errors++;
      $display("FAIL x0_fwd_a: got %b expected 00", bus.forward_a_o);
    end
    drain();
  endtask

  task automatic test_forward_priority();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd7, 5'd7, 5'd10);
    tick();
    nop();
    n_checks++;
    if ({bus.forward_a_o, bus.forward_b_o} !== 4'b10_10) begin
      n_errors++;
      $display("FAIL fwd_mem_priority: got a=%b b=%b expected a=10 b=10",
               bus.forward_a_o, bus.forward_b_o);
    end
    drain();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd0, 5'd0, 5'd8);
    tick();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd7, 5'd7, 5'd10);
    tick();
    nop();
    n_checks++;
    if ({bus.forward_a_o, bus.forward_b_o} !== 4'b01_01) begin
      n_errors++;
      $display("FAIL fwd_wb: got a=%b b=%b expected a=01 b=01",
               bus.forward_a_o, bus.forward_b_o);
    end
    drain();
    // store (no regwrite) to rd=7 must not forward
    set_id(0, 0, 1, 0, 1, 2'b00, 0, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd0, 5'd7, 5'd10);
    tick();
    nop();
    n_checks++;
    if (bus.forward_b_o !== 2'b00) begin
      n_errors++;
      $display("FAIL fwd_no_regwrite: got %b expected 00", bus.forward_b_o);
    end
    drain();
  endtask

  task automatic test_flush();
    // unflushed store reaches MEM two edges later
    set_id(0, 0, 1, 0, 1, 2'b00, 0, 5'd1, 5'd2, 5'd0);
    tick();
    nop();
    tick();
    n_checks++;
    if (bus.mem_memwrite_o !== 1'b1) begin
      n_errors++;
      $display("FAIL store_mem: got %b expected 1", bus.mem_memwrite_o);
    end
    drain();
    // flushed store
    set_id(0, 0, 1, 0, 1, 2'b01, 0, 5'd1, 5'd2, 5'd0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    nop();
    n_checks++;
    if (ex_ctl !== 4'd0) begin
      n_errors++;
      $display("FAIL flush_ex: got %b expected 0000", ex_ctl);
    end
    tick();
    n_checks++;
    if (bus.mem_memwrite_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_mem: got %b expected 0", bus.mem_memwrite_o);
    end
    drain();
    // flush during a stall: still a single bubble
    set_id(0, 1, 0, 1, 1, 2'b00, 1, 5'd1, 5'd0, 5'd3);
    tick();
    set_id(0, 0, 0, 0, 0, 2'b10, 1, 5'd3, 5'd4, 5'd6);
    bus.flush_i = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b1) begin
      n_errors++;
      $display("FAIL flushstall_stall: got %b expected 1", bus.stall_o);
    end
    tick();
    bus.flush_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.stall_o, ex_ctl} !== 5'd0) begin
      n_errors++;
      $display("FAIL flushstall_bubble: got stall=%b ex=%b expected 0/0000",
               bus.stall_o, ex_ctl);
    end
    tick();
    n_checks++;
    if (bus.ex_aluop_o !== 2'b10) begin
      n_errors++;
      $display("FAIL flushstall_dep_ex: got %b expected 10", bus.ex_aluop_o);
    end
    drain();
  endtask

  task automatic test_async_reset();
    set_id(0, 1, 0, 1, 1, 2'b00, 1, 5'd1, 5'd0, 5'd4);
    tick();
    nop();
    tick();
    n_checks++;
    if (bus.mem_memread_o !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_pre: got %b expected 1", bus.mem_memread_o);
    end
    #2 rst_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_memread_o, bus.wb_regwrite_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL areset_immediate: got mr=%b rw=%b expected 0/0",
               bus.mem_memread_o, bus.wb_regwrite_o);
    end
    tick();
    #2 rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.wb_regwrite_o !== 1'b0) begin
        n_errors++;
        $display("FAIL areset_wb[%0d]: got %b expected 0", i, bus.wb_regwrite_o);
      end
    end
  endtask

  initial begin
    nop();
    bus.flush_i = 1'b0;
    test_reset();
    test_load_use();
    test_x0_guard();
    test_forward_priority();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
